dma_word_serializer: RTL and testbench
======================================

Name: dma_word_serializer

Overview:
- Upstream select-generator stage for the 32:1 single-bit mux in the BASIC_DMA64 FPGA library.
- Accepts a 32-bit DMA word with a programmable bit count through a valid/ready handshake.
- Steps a 5-bit select across the held word, one bit per output handshake, and emits a serial bit stream with last-bit marking.
- Supports back-to-back words with no bubble, and a synchronous abort.

Parameters:
- SEL_W, 5, select width; word width WORD_W = 2**SEL_W = 32.
- MSB_FIRST, 0, 0 = emit bit 0 first, counting up; 1 = emit bit in_len first, counting down to 0.

Ports:
- clk  in  1  rising-edge clock
- rst  in  1  asynchronous active-high reset
- in_data  in  WORD_W  word to serialize
- in_len  in  SEL_W  number of bits to emit minus 1 (0 means 1 bit, 31 means 32 bits)
- in_valid  in  1  upstream word valid
- in_ready  out  1  upstream ready (combinational)
- abort  in  1  synchronous abort of the current word
- out_bit  out  1  selected bit, held_word[sel]
- out_valid  out  1  out_bit valid
- out_ready  in  1  downstream accept
- out_last  out  1  out_bit is the final bit of the word
- sel  out  SEL_W  current bit index (mux select)
- busy  out  1  state == SHIFT

Behaviour:
- Reset (async, rst=1): state=IDLE, held_word=0, held_len=0, sel=0, out_valid=0, out_last=0, busy=0. in_ready equals 1 during reset (IDLE) but loads are ignored while rst=1.
- States: IDLE and SHIFT. out_valid = (state==SHIFT).
- Load condition: load = in_valid & in_ready.
- in_ready = ~abort & ((state==IDLE) | (out_valid & out_ready & out_last)).
- On load, at the clock edge:
  - held_word <= in_data; held_len <= in_len; state <= SHIFT.
  - sel <= 0 when MSB_FIRST=0, or sel <= in_len when MSB_FIRST=1.
- Latency: word accepted at edge N; first bit valid in the cycle after edge N.
- In SHIFT, out_bit = held_word[sel], combinational from registers.
- The end index is held_len when MSB_FIRST=0, or 0 when MSB_FIRST=1. out_last = (state==SHIFT) & (sel == end index).
- On a bit handshake (out_valid & out_ready):
  - If not last: sel advances by +1 (MSB_FIRST=0) or -1 (MSB_FIRST=1).
  - If last and a load occurs in the same cycle: reload as above, stay in SHIFT. Zero-bubble back-to-back operation.
  - If last and no load: state <= IDLE, sel <= 0.
- Stall: with out_ready=0, out_bit, sel and out_last are held stable and out_valid stays 1. The value never changes while valid and not accepted.
- held_len=31 with MSB_FIRST=0: sel reaches 31 and does not wrap. Completion returns to IDLE with sel=0.
- held_len=0: a single bit, where out_last=1 on the first output cycle.
- abort=1 at an edge: state <= IDLE, sel <= 0, and any bit handshake that cycle is discarded. abort forces in_ready=0, so abort has priority over a simultaneous load.
- Async rst mid-word: the word is discarded immediately. No partial output survives reset.
- in_data and in_len are ignored unless a load occurs.

Decomposition:
- Shared package dma_ser_pkg:
  - SEL_W and WORD_W constants.
  - State encoding enum: IDLE=0, SHIFT=1.
  - Function next_sel(sel, dir).
- One natural sub-module, ser_sel_counter: a load/step/clear counter with end-compare that produces sel and out_last. The top block holds the word register, the FSM and the handshake logic.

Test Plan:
- Single word, MSB_FIRST=0: in_data=0xA5A5_0F0F, in_len=31, out_ready=1 → 32 bits LSB-first, starting 1,1,1,1,0,0,0,0…; out_last only at sel=31; then IDLE, in_ready=1.
- MSB_FIRST=1, in_data=0x0000_000B, in_len=3 → bits 1,0,1,1 with sel 3,2,1,0; out_last at sel=0.
- Back-to-back: second word valid during the last bit of the first → in_ready=1 in that cycle; the first bit of the second word appears the next cycle with no gap in out_valid.
- Backpressure: out_ready toggled 1,0,0,1 mid-word → out_bit and sel held during stall; no bit skipped or repeated.
- abort at bit 5 while in_valid=1 → in_ready=0, next cycle IDLE, sel=0, no load; a subsequent word serializes normally.
- Async rst asserted mid-word between edges → out_valid=0 and sel=0 immediately; in_len=0 word afterwards → exactly one bit, with out_last=1.

Source files
------------

// File: rtl/dma_ser_pkg.sv
// dma_ser_pkg: shared widths, state encoding and select-step helper for the word serializer
package dma_ser_pkg;

    localparam int SEL_W  = 5;
    localparam int WORD_W = 2 ** SEL_W;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    // dir=0 counts up (LSB first), dir=1 counts down (MSB first)
    function automatic logic [SEL_W-1:0] next_sel(input logic [SEL_W-1:0] sel, input logic dir);
        return dir ? sel - SEL_W'(1) : sel + SEL_W'(1);
    endfunction

endpackage

// File: rtl/dma_word_serializer_sel_counter.sv
// ser_sel_counter: mux select counter with load/step/clear and end-index compare
module ser_sel_counter
    import dma_ser_pkg::*;
#(
    parameter int SEL_W = 5,
    parameter bit DIR   = 1'b0
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             active,
    input  logic             clear,
    input  logic             load,
    input  logic [SEL_W-1:0] load_val,
    input  logic             step,
    input  logic [SEL_W-1:0] end_val,
    output logic [SEL_W-1:0] sel,
    output logic             last
);

    logic [SEL_W-1:0] sel_d, sel_q;

    // clear wins over load so an abort can never start a new word
    always_comb begin
        sel_d = clear ? '0 : load ? load_val : step ? next_sel(sel_q, DIR) : sel_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) sel_q <= '0;
        else     sel_q <= sel_d;
    end

    assign sel  = sel_q;
    assign last = active & (sel_q == end_val);

endmodule

// File: rtl/dma_word_serializer.sv
// dma_word_serializer: holds a DMA word and steps a mux select across it, one bit per output handshake
module dma_word_serializer
    import dma_ser_pkg::*;
#(
    parameter int SEL_W     = 5,
    parameter bit MSB_FIRST = 1'b0
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [2**SEL_W-1:0]   in_data,
    input  logic [SEL_W-1:0]      in_len,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  abort,
    output logic                  out_bit,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic                  out_last,
    output logic [SEL_W-1:0]      sel,
    output logic                  busy
);

    state_t              state_d, state_q;
    logic [2**SEL_W-1:0] word_d, word_q;
    logic [SEL_W-1:0]    len_d, len_q;
    logic                hs, load, done;

    assign out_valid = (state_q == SHIFT);
    assign busy      = out_valid;
    assign hs        = out_valid & out_ready;
    assign done      = hs & out_last;
    // a finishing word frees the register in the same cycle, giving zero-bubble reloads
    assign in_ready  = ~abort & (~out_valid | done);
    assign load      = in_valid & in_ready;
    assign out_bit   = word_q[sel];

    always_comb begin
        state_d = abort ? IDLE : load ? SHIFT : done ? IDLE : state_q;
        word_d  = load ? in_data : word_q;
        len_d   = load ? in_len : len_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            word_q  <= '0;
            len_q   <= '0;
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            len_q   <= len_d;
        end
    end

    ser_sel_counter #(
        .SEL_W (SEL_W),
        .DIR   (MSB_FIRST)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .active   (out_valid),
        .clear    (abort | (done & ~load)),
        .load     (load),
        .load_val (MSB_FIRST ? in_len : '0),
        .step     (hs & ~out_last),
        .end_val  (MSB_FIRST ? '0 : len_q),
        .sel      (sel),
        .last     (out_last)
    );

endmodule

// File: tb/tb_dma_word_serializer.sv
// tb_dma_word_serializer: directed checks of an LSB-first and an MSB-first serializer sharing one stimulus
module tb_dma_word_serializer;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] in_data = '0;
    logic [4:0]  in_len = '0;
    logic        in_valid = 1'b0;
    logic        abort = 1'b0;
    logic        out_ready = 1'b1;

    logic       in_ready0, out_bit0, out_valid0, out_last0, busy0;
    logic [4:0] sel0;
    logic       in_ready1, out_bit1, out_valid1, out_last1, busy1;
    logic [4:0] sel1;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    dma_word_serializer #(.SEL_W(5), .MSB_FIRST(1'b0)) u0 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_len(in_len), .in_valid(in_valid),
        .in_ready(in_ready0), .abort(abort), .out_bit(out_bit0), .out_valid(out_valid0),
        .out_ready(out_ready), .out_last(out_last0), .sel(sel0), .busy(busy0)
    );

    dma_word_serializer #(.SEL_W(5), .MSB_FIRST(1'b1)) u1 (
        .clk(clk), .rst(rst), .in_data(in_data), .in_len(in_len), .in_valid(in_valid),
        .in_ready(in_ready1), .abort(abort), .out_bit(out_bit1), .out_valid(out_valid1),
        .out_ready(out_ready), .out_last(out_last1), .sel(sel1), .busy(busy1)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic load_word(input logic [31:0] d, input logic [4:0] l);
        in_data = d; in_len = l; in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        #1;
        tests++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b exp 0", out_valid0); end
        tests++; if (sel0 !== 5'd0) begin fails++; $display("FAIL reset_sel: got %0d exp 0", sel0); end
        tests++; if (out_last0 !== 1'b0 || busy0 !== 1'b0) begin fails++; $display("FAIL reset_last_busy: got %b%b exp 00", out_last0, busy0); end
        tests++; if (in_ready0 !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b exp 1", in_ready0); end
        in_valid = 1'b1; in_data = 32'hFFFF_FFFF;
        tick();
        tests++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL reset_load_ignored: got %b exp 0", out_valid0); end
        in_valid = 1'b0;
        rst = 1'b0;
        tick();
    endtask

    task automatic test_lsb_word();
        logic [31:0] d;
        d = 32'hA5A5_0F0F;
        load_word(d, 5'd31);
        for (int i = 0; i < 32; i++) begin
            tests++; if (out_valid0 !== 1'b1 || sel0 !== 5'(i)) begin fails++; $display("FAIL lsb_sel%0d: got v=%b sel=%0d exp v=1 sel=%0d", i, out_valid0, sel0, i); end
            tests++; if (out_bit0 !== d[i]) begin fails++; $display("FAIL lsb_bit%0d: got %b exp %b", i, out_bit0, d[i]); end
            tests++; if (out_last0 !== (i == 31)) begin fails++; $display("FAIL lsb_last%0d: got %b exp %b", i, out_last0, i == 31); end
            tick();
        end
        tests++; if (out_valid0 !== 1'b0 || in_ready0 !== 1'b1 || sel0 !== 5'd0) begin fails++; $display("FAIL lsb_idle: got v=%b rdy=%b sel=%0d exp v=0 rdy=1 sel=0", out_valid0, in_ready0, sel0); end
    endtask

    task automatic test_msb_word();
        logic [3:0] exp_bits;
        exp_bits = 4'b1101;
        load_word(32'h0000_000B, 5'd3);
        for (int i = 0; i < 4; i++) begin
            tests++; if (sel1 !== 5'(3 - i) || out_bit1 !== exp_bits[i]) begin fails++; $display("FAIL msb_step%0d: got sel=%0d bit=%b exp sel=%0d bit=%b", i, sel1, out_bit1, 3 - i, exp_bits[i]); end
            tests++; if (out_last1 !== (i == 3)) begin fails++; $display("FAIL msb_last%0d: got %b exp %b", i, out_last1, i == 3); end
            tick();
        end
        tests++; if (out_valid1 !== 1'b0 || sel1 !== 5'd0) begin fails++; $display("FAIL msb_idle: got v=%b sel=%0d exp v=0 sel=0", out_valid1, sel1); end
    endtask

    task automatic test_back_to_back();
        load_word(32'h0000_0005, 5'd2);
        tick();
        tick();
        in_data = 32'h0000_0002; in_len = 5'd1; in_valid = 1'b1;
        #1;
        tests++; if (out_last0 !== 1'b1 || in_ready0 !== 1'b1) begin fails++; $display("FAIL b2b_ready: got last=%b rdy=%b exp last=1 rdy=1", out_last0, in_ready0); end
        tick();
        in_valid = 1'b0;
        #1;
        tests++; if (out_valid0 !== 1'b1 || sel0 !== 5'd0 || out_bit0 !== 1'b0) begin fails++; $display("FAIL b2b_first: got v=%b sel=%0d bit=%b exp v=1 sel=0 bit=0", out_valid0, sel0, out_bit0); end
        tick();
        tests++; if (sel0 !== 5'd1 || out_bit0 !== 1'b1 || out_last0 !== 1'b1) begin fails++; $display("FAIL b2b_second: got sel=%0d bit=%b last=%b exp sel=1 bit=1 last=1", sel0, out_bit0, out_last0); end
        tick();
        tests++; if (out_valid0 !== 1'b0) begin fails++; $display("FAIL b2b_idle: got %b exp 0", out_valid0); end
    endtask

    task automatic test_backpressure();
        logic [31:0] d;
        int exp_sel;
        bit fin;
        d = 32'h0000_0036;
        exp_sel = 0;
        fin = 1'b0;
        load_word(d, 5'd5);
        for (int c = 0; c < 20 && !fin; c++) begin
            out_ready = !(c == 1 || c == 2);
            #1;
            tests++; if (out_valid0 !== 1'b1 || sel0 !== 5'(exp_sel) || out_bit0 !== d[exp_sel]) begin fails++; $display("FAIL bp_cycle%0d: got v=%b sel=%0d bit=%b exp v=1 sel=%0d bit=%b", c, out_valid0, sel0, out_bit0, exp_sel, d[exp_sel]); end
            tests++; if (out_last0 !== (exp_sel == 5)) begin fails++; $display("FAIL bp_last%0d: got %b exp %b", c, out_last0, exp_sel == 5); end
            if (out_ready && exp_sel == 5) fin = 1'b1;
            else if (out_ready) exp_sel++;
            tick();
        end
        out_ready = 1'b1;
        tests++; if (!fin || out_valid0 !== 1'b0) begin fails++; $display("FAIL bp_done: got fin=%b v=%b exp fin=1 v=0", fin, out_valid0); end
    endtask

    task automatic test_abort();
        load_word(32'hFFFF_FFFF, 5'd10);
        for (int i = 0; i < 5; i++) tick();
        tests++; if (sel0 !== 5'd5) begin fails++; $display("FAIL abort_pre_sel: got %0d exp 5", sel0); end
        abort = 1'b1; in_valid = 1'b1; in_data = 32'h0000_0003; in_len = 5'd1;
        #1;
        tests++; if (in_ready0 !== 1'b0) begin fails++; $display("FAIL abort_in_ready: got %b exp 0", in_ready0); end
        tick();
        abort = 1'b0; in_valid = 1'b0;
        #1;
        tests++; if (out_valid0 !== 1'b0 || sel0 !== 5'd0 || busy0 !== 1'b0) begin fails++; $display("FAIL abort_idle: got v=%b sel=%0d busy=%b exp 0 0 0", out_valid0, sel0, busy0); end
        load_word(32'h0000_0002, 5'd1);
        tests++; if (out_valid0 !== 1'b1 || sel0 !== 5'd0 || out_bit0 !== 1'b0) begin fails++; $display("FAIL abort_next0: got v=%b sel=%0d bit=%b exp 1 0 0", out_valid0, sel0, out_bit0); end
        tick();
        tests++; if (sel0 !== 5'd1 || out_bit0 !== 1'b1 || out_last0 !== 1'b1) begin fails++; $display("FAIL abort_next1: got sel=%0d bit=%b last=%b exp 1 1 1", sel0, out_bit0, out_last0); end
        tick();
    endtask

    task automatic test_async_reset();
        load_word(32'h0000_00F0, 5'd7);
        tick();
        tick();
        #2 rst = 1'b1;
        #1;
        tests++; if (out_valid0 !== 1'b0 || sel0 !== 5'd0) begin fails++; $display("FAIL arst_now: got v=%b sel=%0d exp v=0 sel=0", out_valid0, sel0); end
        tests++; if (out_valid1 !== 1'b0 || sel1 !== 5'd0) begin fails++; $display("FAIL arst_now_msb: got v=%b sel=%0d exp v=0 sel=0", out_valid1, sel1); end
        #1 rst = 1'b0;
        tick();
        load_word(32'h0000_0001, 5'd0);
        tests++; if (out_valid0 !== 1'b1 || out_last0 !== 1'b1 || out_bit0 !== 1'b1 || sel0 !== 5'd0) begin fails++; $display("FAIL len0_lsb: got v=%b last=%b bit=%b sel=%0d exp 1 1 1 0", out_valid0, out_last0, out_bit0, sel0); end
        tests++; if (out_last1 !== 1'b1 || out_bit1 !== 1'b1) begin fails++; $display("FAIL len0_msb: got last=%b bit=%b exp 1 1", out_last1, out_bit1); end
        tick();
        tests++; if (out_valid0 !== 1'b0 || out_valid1 !== 1'b0) begin fails++; $display("FAIL len0_idle: got %b%b exp 00", out_valid0, out_valid1); end
    endtask

    initial begin
        test_reset();
        test_lsb_word();
        test_msb_word();
        test_back_to_back();
        test_backpressure();
        test_abort();
        test_async_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
